// File: rtl/cond_flag_unit.sv
// NZCV flag register plus ARM condition evaluation, with one outstanding flag write tracked until ALU completion.
// Define FLAG_BYPASS_EN to accept a request in the flag-completion cycle, evaluated against the merged flags.
module cond_flag_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cond_valid,
  output logic       cond_ready,
  input  logic [3:0] Cond,
  input  logic [1:0] FlagW,
  input  logic       flag_valid,
  input  logic [3:0] ALUFlags,
  output logic       ex_valid,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       flag_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_flags;
  logic [1:0]         r_flagw;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_ex_valid;
  logic               r_cond_ex;

  logic [3:0]         w_flags_nxt;
  logic [1:0]         w_flagw_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_err_nxt;
  logic               w_cond_ex_nxt;

  logic               w_accept;
  logic               w_flag_done;
  logic               w_timeout;
  logic               w_open;
  logic               w_cond_ex;
  logic [3:0]         w_merged;
  logic [3:0]         w_eval_flags;

  // Condition field decode against {N,Z,C,V}
  function automatic logic f_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    f_cond = z;
      4'h1:    f_cond = ~z;
      4'h2:    f_cond = cy;
      4'h3:    f_cond = ~cy;
      4'h4:    f_cond = n;
      4'h5:    f_cond = ~n;
      4'h6:    f_cond = v;
      4'h7:    f_cond = ~v;
      4'h8:    f_cond = cy & ~z;
      4'h9:    f_cond = ~cy | z;
      4'hA:    f_cond = (n == v);
      4'hB:    f_cond = (n != v);
      4'hC:    f_cond = ~z & (n == v);
      4'hD:    f_cond = z | (n != v);
      default: f_cond = 1'b1;
    endcase
  endfunction

  assign w_merged    = {r_flagw[1] ? ALUFlags[3:2] : r_flags[3:2],
                        r_flagw[0] ? ALUFlags[1:0] : r_flags[1:0]};
  assign w_flag_done = (r_state == S_WAIT) & flag_valid;
  assign w_timeout   = (r_state == S_WAIT) & ~flag_valid & (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_accept    = cond_valid & cond_ready;
`ifdef FLAG_BYPASS_EN
  assign w_eval_flags = w_flag_done ? w_merged : r_flags;
`else
  assign w_eval_flags = r_flags;
`endif
  assign w_cond_ex   = f_cond(Cond, w_eval_flags);
  assign w_open      = w_accept & w_cond_ex & (FlagW != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_open) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (flag_valid)     w_state_nxt = w_open ? S_WAIT : S_IDLE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and next values for the registered datapath
  always_comb begin
    cond_ready    = 1'b1;
    w_flags_nxt   = r_flags;
    w_flagw_nxt   = r_flagw;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err | w_timeout;
    w_cond_ex_nxt = w_accept ? w_cond_ex : r_cond_ex;
    if (r_state == S_WAIT) begin
`ifdef FLAG_BYPASS_EN
      cond_ready = flag_valid;
`else
      cond_ready = 1'b0;
`endif
      if (flag_valid)      w_flags_nxt = w_merged;
      else if (!w_timeout) w_cnt_nxt   = r_cnt + CNT_W'(1);
    end
    if (w_open) begin
      w_flagw_nxt = FlagW;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags    <= 4'b0000;
      r_flagw    <= 2'b00;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_ex_valid <= 1'b0;
      r_cond_ex  <= 1'b0;
    end else begin
      r_flags    <= w_flags_nxt;
      r_flagw    <= w_flagw_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_ex_valid <= w_accept;
      r_cond_ex  <= w_cond_ex_nxt;
    end
  end

  assign Flags    = r_flags;
  assign flag_err = r_err;
  assign ex_valid = r_ex_valid;
  assign CondEx   = r_cond_ex;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Randomised and directed bench for cond_flag_unit against a behavioural flag/condition model.
module tb_cond_flag_unit;

  localparam int unsigned TO = 4;
`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cond_valid;
  logic       cond_ready;
  logic [3:0] Cond;
  logic [1:0] FlagW;
  logic       flag_valid;
  logic [3:0] ALUFlags;
  logic       ex_valid;
  logic       CondEx;
  logic [3:0] Flags;
  logic       flag_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit [3:0] m_flags;
  bit       m_pending;
  bit [1:0] m_mask;
  int       m_waited;
  bit       m_err;
  bit       m_condex;

  cond_flag_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cond_valid(cond_valid), .cond_ready(cond_ready),
    .Cond(Cond), .FlagW(FlagW), .flag_valid(flag_valid), .ALUFlags(ALUFlags),
    .ex_valid(ex_valid), .CondEx(CondEx), .Flags(Flags), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit holds(input bit [3:0] c, input bit [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      0: return z;        1: return !z;
      2: return cy;       3: return !cy;
      4: return n;        5: return !n;
      6: return v;        7: return !v;
      8: return cy && !z; 9: return !cy || z;
      10: return n == v;  11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    m_flags = 0; m_pending = 0; m_mask = 0; m_waited = 0; m_err = 0; m_condex = 0;
  endfunction

  // One clock: drive at posedge+1, check ready before the edge, outputs after it
  task automatic step(input bit cv, input bit [3:0] cnd, input bit [1:0] fw,
                      input bit fv, input bit [3:0] alu);
    bit       rdy, acc, ex, exp_exv;
    bit [3:0] merged, ef;
    cond_valid = cv; Cond = cnd; FlagW = fw; flag_valid = fv; ALUFlags = alu;
    #1;
    rdy = !m_pending || (BYP && fv);
    chk("cond_ready", {3'b0, cond_ready}, {3'b0, rdy});
    merged[3:2] = m_mask[1] ? alu[3:2] : m_flags[3:2];
    merged[1:0] = m_mask[0] ? alu[1:0] : m_flags[1:0];
    ef  = (m_pending && fv && BYP) ? merged : m_flags;
    acc = cv && rdy;
    ex  = holds(cnd, ef);
    exp_exv = acc;
    if (acc) m_condex = ex;
    if (m_pending) begin
      if (fv) begin
        m_flags = merged; m_pending = 0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin m_err = 1; m_pending = 0; end
      end
    end
    if (acc && ex && fw != 2'b00) begin
      m_pending = 1; m_mask = fw; m_waited = 0;
    end
    @(posedge clk); #1;
    chk("ex_valid", {3'b0, ex_valid}, {3'b0, exp_exv});
    chk("CondEx",   {3'b0, CondEx},   {3'b0, m_condex});
    chk("Flags",    Flags,            m_flags);
    chk("flag_err", {3'b0, flag_err}, {3'b0, m_err});
  endtask

  task automatic idle_inputs();
    cond_valid = 0; Cond = 0; FlagW = 0; flag_valid = 0; ALUFlags = 0;
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge
  task automatic mid_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_flags",  Flags, 4'b0000);
    chk("rst_ready",  {3'b0, cond_ready}, 4'b0001);
    chk("rst_exv",    {3'b0, ex_valid},   4'b0000);
    chk("rst_err",    {3'b0, flag_err},   4'b0000);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_flags", Flags, 4'b0000);
    chk("init_ready", {3'b0, cond_ready}, 4'b0001);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Full flag write then EQ / NE
    step(1, 4'hE, 2'b11, 0, 4'h0);
    step(0, 4'h0, 2'b00, 1, 4'b0100);
    chk("t2_flags", Flags, 4'b0100);
    step(1, 4'h0, 2'b00, 0, 4'h0);
    chk("t2_eq", {3'b0, CondEx}, 4'b0001);
    step(1, 4'h1, 2'b00, 0, 4'h0);
    chk("t2_ne", {3'b0, CondEx}, 4'b0000);

    // N,Z-only write then LT
    step(1, 4'hE, 2'b10, 0, 4'h0);
    step(0, 4'h0, 2'b00, 1, 4'b1011);
    chk("t3_flags", Flags, 4'b1000);
    step(1, 4'hB, 2'b00, 0, 4'h0);
    chk("t3_lt", {3'b0, CondEx}, 4'b0001);

    // Failing condition does not open a flag write
    step(1, 4'hE, 2'b11, 0, 4'h0);
    step(0, 4'h0, 2'b00, 1, 4'b0100);
    step(1, 4'h1, 2'b11, 0, 4'h0);
    chk("t4_ne", {3'b0, CondEx}, 4'b0000);
    chk("t4_ready", {3'b0, cond_ready}, 4'b0001);

    // Timeout after TO wait cycles, later flag_valid ignored
    step(1, 4'hE, 2'b01, 0, 4'h0);
    for (int i = 0; i < int'(TO); i++) step(0, 4'h0, 2'b00, 0, 4'hF);
    chk("t5_err", {3'b0, flag_err}, 4'b0001);
    chk("t5_flags", Flags, 4'b0100);
    step(0, 4'h0, 2'b00, 1, 4'b1111);
    chk("t5_ignore", Flags, 4'b0100);

    // Request arriving together with flag completion
    step(1, 4'hE, 2'b11, 0, 4'h0);
    step(1, 4'h0, 2'b00, 1, 4'b0100);
    if (!BYP) step(1, 4'h0, 2'b00, 0, 4'h0);
    chk("t6_exv", {3'b0, ex_valid}, 4'b0001);
    chk("t6_eq",  {3'b0, CondEx},   4'b0001);

    // Reset while a flag write is pending, with flag_err previously set
    step(1, 4'hE, 2'b11, 0, 4'h0);
    mid_reset();

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom), 2'($urandom),
           $urandom_range(0, 9) < 3, 4'($urandom));
      if (i == 300) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
